// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : uart_pkg                                                       |
// | Purpose   : Shared UART-side constants, arbiter state encoding, helpers.   |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package uart_pkg;

  localparam int BYTE_W        = 8;
  localparam int START_TMO_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SEND       = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } arb_state_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : rr_pick                                                        |
// | Purpose   : Combinational round-robin picker with an optional owner lock.  |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module rr_pick
  import uart_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             lock,
  input  logic [PTR_W-1:0] lock_id,
  output logic             found,
  output logic [PTR_W-1:0] g
);

  logic [PTR_W-1:0] w_idx;

  // A lock whose owner has gone quiet falls through to a normal scan.
  always_comb begin
    found = 1'b0;
    g     = '0;
    w_idx = '0;
    if (lock && req[lock_id]) begin
      found = 1'b1;
      g     = lock_id;
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        w_idx = PTR_W'((int'(ptr) + k) % N);
        if (req[w_idx]) begin
          found = 1'b1;
          g     = w_idx;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : uart_tx_arbiter                                                |
// | Purpose   : Byte-granular round-robin sharing of one UART transmitter,     |
// |             with frame lock and start-of-byte timeout.                     |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int START_TMO = START_TMO_DEF,
  parameter int PTR_W     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [BYTE_W*N_REQ-1:0] dat,
  input  logic [N_REQ-1:0]        last,
  output logic [N_REQ-1:0]        ack,
  output logic                    uart_wr,
  output logic [BYTE_W-1:0]       uart_dat,
  input  logic                    uart_busy,
  output logic [PTR_W-1:0]        grant_id,
  output logic                    busy,
  output logic                    tmo_err
);

  localparam int CNT_W = (START_TMO > 1) ? $clog2(START_TMO) : 1;

  arb_state_t        r_state, w_state_nxt;
  logic [PTR_W-1:0]  r_ptr, w_ptr_nxt;
  logic              r_lock, w_lock_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [N_REQ-1:0]  r_ack, w_ack_nxt;
  logic              r_wr, w_wr_nxt;
  logic [BYTE_W-1:0] r_dat, w_dat_nxt;
  logic [PTR_W-1:0]  r_gid, w_gid_nxt;
  logic              r_tmo, w_tmo_nxt;

  logic              w_found;
  logic [PTR_W-1:0]  w_g;
  logic [BYTE_W-1:0] w_dat_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign w_dat_arr[i] = dat[i*BYTE_W +: BYTE_W];
  end

  rr_pick #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req     (req),
    .ptr     (r_ptr),
    .lock    (r_lock),
    .lock_id (r_gid),
    .found   (w_found),
    .g       (w_g)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr  <= '0;
      r_lock <= 1'b0;
      r_cnt  <= '0;
      r_ack  <= '0;
      r_wr   <= 1'b0;
      r_dat  <= '0;
      r_gid  <= '0;
      r_tmo  <= 1'b0;
    end else begin
      r_ptr  <= w_ptr_nxt;
      r_lock <= w_lock_nxt;
      r_cnt  <= w_cnt_nxt;
      r_ack  <= w_ack_nxt;
      r_wr   <= w_wr_nxt;
      r_dat  <= w_dat_nxt;
      r_gid  <= w_gid_nxt;
      r_tmo  <= w_tmo_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_lock_nxt  = r_lock;
    w_cnt_nxt   = r_cnt;
    w_ack_nxt   = '0;
    w_wr_nxt    = 1'b0;
    w_dat_nxt   = r_dat;
    w_gid_nxt   = r_gid;
    w_tmo_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_lock && !req[r_gid]) w_lock_nxt = 1'b0;
        if (!uart_busy && w_found) begin
          w_state_nxt    = ST_SEND;
          w_gid_nxt      = w_g;
          w_dat_nxt      = w_dat_arr[w_g];
          w_wr_nxt       = 1'b1;
          w_ack_nxt[w_g] = 1'b1;
          w_lock_nxt     = !last[w_g];
          if (last[w_g]) w_ptr_nxt = PTR_W'(wrap_inc(int'(w_g), N_REQ));
        end
      end
      ST_SEND: begin
        w_state_nxt = ST_WAIT_START;
        w_cnt_nxt   = '0;
      end
      ST_WAIT_START: begin
        if (uart_busy) begin
          w_state_nxt = ST_WAIT_DONE;
        end else if (r_cnt == CNT_W'(START_TMO - 1)) begin
          // The byte is dropped; move on so a dead UART cannot pin one requester.
          w_state_nxt = ST_IDLE;
          w_tmo_nxt   = 1'b1;
          w_lock_nxt  = 1'b0;
          w_ptr_nxt   = PTR_W'(wrap_inc(int'(r_gid), N_REQ));
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!uart_busy) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign ack      = r_ack;
  assign uart_wr  = r_wr;
  assign uart_dat = r_dat;
  assign grant_id = r_gid;
  assign tmo_err  = r_tmo;
  assign busy     = (r_state != ST_IDLE) | r_lock;

endmodule
`default_nettype wire
